alu_op_arbiter: RTL and testbench
=================================

Name: alu_op_arbiter

Overview:
- Shares one 4-bit ALU slice (NOR/AND/OR/XOR/ADD/SUB bit-slices) between two requesters (r0, r1).
- Round-robin arbitration, req/gnt handshake, operand capture, one ALU dispatch, fixed-latency wait, registered result return.
- Sits between the requesting control logic and the combinational 4-bit ALU datapath.

Parameters:
- ALU_LAT, 2, cycles from ALU dispatch to result sample; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  request from r0 / r1; held high until its gnt pulse
- op0 / op1  in  3  opcode: 0 NOR, 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB, 6-7 reserved
- a0_in / a1_in  in  4  operand A per requester
- b0_in / b1_in  in  4  operand B per requester
- gnt0 / gnt1  out  1  one-cycle grant pulse; operands were captured at the edge that raised it
- rvalid0 / rvalid1  out  1  one-cycle result-valid pulse to the granted requester
- result  out  4  result, valid when either rvalid is high
- cout  out  1  ADD carry / SUB borrow-not; 0 for logic ops
- err  out  1  high with rvalid when the opcode was reserved
- busy  out  1  high in every state except IDLE
- alu_op  out  3  opcode to the ALU, held from ISSUE through WAIT
- alu_a, alu_b  out  4  operands to the ALU, held from ISSUE through WAIT
- alu_en  out  1  one-cycle dispatch strobe, high in ISSUE
- alu_y  in  4  ALU result
- alu_co  in  1  ALU carry out

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. State register is 2 bits. Wait counter is 4 bits.
- Reset (rst_n low at an edge), whether idle or mid-operation:
  - State goes to IDLE.
  - All outputs go to 0: gnt*, rvalid*, result, cout, err, busy, alu_*.
  - Last-served pointer goes to 1, so r0 wins the first tie.
  - Any in-flight operation is dropped. No rvalid follows.
- IDLE: arbitration is sampled at the clock edge.
  - One request high: that requester is granted.
  - Both high: the requester other than the last-served one is granted, and the pointer is updated.
  - At the grant edge: the winner's op/a/b are latched, the owner ID is stored, and gnt for the winner is high during the next cycle.
  - Next state: ISSUE for legal opcodes, RESP with err=1 for opcodes 6-7.
  - No request: stay in IDLE.
- ISSUE: alu_en=1 for exactly one cycle and alu_op/alu_a/alu_b are driven from the latches. Next state is WAIT, with the counter loaded to ALU_LAT-1.
- WAIT: alu_* stay held and alu_en=0.
  - Counter not 0: decrement.
  - Counter 0: at that edge, latch alu_y into result and alu_co into cout (cout forced to 0 for ops 0-3), then go to RESP.
  - WAIT therefore lasts exactly ALU_LAT cycles.
- RESP: the owner's rvalid is high for one cycle with result/cout/err stable. Next state is always IDLE, so there is one idle cycle between operations.
- Reserved opcode path: result=0, cout=0, err=1. The ALU is never strobed.
- result/cout/err hold their value after RESP until the next RESP overwrites them.
- Latency, grant edge to rvalid edge: ALU_LAT+2 edges for legal ops, 1 edge for reserved ops.
- A request raised or dropped while busy=1 is ignored. Only the level seen in IDLE counts, and a request dropped before that edge is never granted.
- gnt and rvalid are never high for both requesters in the same cycle.
- Operands changing after the grant edge have no effect on the operation in flight.

Test Plan:
- Single NOR on r0: req0=1, op0=0, a0_in=0101, b0_in=0011, ALU_LAT=2 -> gnt0 pulse after edge 0, alu_en after edge 1, rvalid0 after edge 4, result=1000, cout=0, err=0.
- ADD overflow on r1: op1=4, a1_in=1011, b1_in=0110 -> rvalid1 with result=0001, cout=1; gnt0/rvalid0 stay 0 throughout.
- Contention: req0 and req1 held high continuously after reset -> grant order r0, r1, r0, r1; each grant is 6 cycles after the previous one with ALU_LAT=2.
- Reserved opcode: req0=1, op0=7 -> gnt0, then rvalid0 on the next cycle with err=1, result=0000; alu_en never asserts.
- Reset mid-WAIT: rst_n=0 for one edge during WAIT -> all outputs 0 the next cycle, no rvalid ever follows. A subsequent tie grants r0.
- Request while busy: req1 pulsed for one cycle during r0's WAIT and dropped -> no gnt1. Operand changes on a0_in during WAIT -> result unchanged.

Source files
------------

// File: rtl/alu_op_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two req/gnt channels with their
// operands, plus the shared result return path.
interface alu_op_arbiter_if;
  logic       req0;
  logic       req1;
  logic [2:0] op0;
  logic [2:0] op1;
  logic [3:0] a0_in;
  logic [3:0] a1_in;
  logic [3:0] b0_in;
  logic [3:0] b1_in;
  logic       gnt0;
  logic       gnt1;
  logic       rvalid0;
  logic       rvalid1;
  logic [3:0] result;
  logic       cout;
  logic       err;

  // Requesting control logic side
  modport master (
    output req0, req1, op0, op1, a0_in, a1_in, b0_in, b1_in,
    input  gnt0, gnt1, rvalid0, rvalid1, result, cout, err
  );

  // Arbiter side
  modport slave (
    input  req0, req1, op0, op1, a0_in, a1_in, b0_in, b1_in,
    output gnt0, gnt1, rvalid0, rvalid1, result, cout, err
  );
endinterface

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one combinational 4-bit ALU slice between two
// requesters. A grant captures the winner's opcode/operands, the ALU is
// strobed once, the result is sampled a fixed ALU_LAT cycles after dispatch
// and returned to the owner with a one-cycle rvalid pulse.
module alu_op_arbiter #(
  parameter int ALU_LAT = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_op_arbiter_if.slave bus,
  output logic           busy,
  output logic [2:0]     alu_op,
  output logic [3:0]     alu_a,
  output logic [3:0]     alu_b,
  output logic           alu_en,
  input  logic [3:0]     alu_y,
  input  logic           alu_co
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;   // 0: r0 owns the operation in flight, 1: r1
  logic       last;    // last-served requester
  logic       pick;
  logic [2:0] win_op;
  logic [3:0] win_a;
  logic [3:0] win_b;

  // Carry is only meaningful for ADD/SUB (opcodes 4/5 have bit 2 set)
  function automatic logic mask_cout(input logic [2:0] op, input logic co);
    return op[2] & co;
  endfunction

  // Opcodes 6 and 7 have no ALU function
  function automatic logic is_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Winner selection: a lone request wins, a tie goes to the one not served last
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last;
    else if (bus.req1)        pick = 1'b1;
    win_op = pick ? bus.op1   : bus.op0;
    win_a  = pick ? bus.a1_in : bus.a0_in;
    win_b  = pick ? bus.b1_in : bus.b0_in;
  end

  // Control FSM with registered outputs; the operand latches double as alu_*
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last        <= 1'b1;
      busy        <= 1'b0;
      alu_op      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_en      <= 1'b0;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      bus.result  <= '0;
      bus.cout    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
      alu_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner    <= pick;
            last     <= pick;
            bus.gnt0 <= ~pick;
            bus.gnt1 <= pick;
            alu_op   <= win_op;
            alu_a    <= win_a;
            alu_b    <= win_b;
            busy     <= 1'b1;
            if (is_reserved(win_op)) begin
              bus.result <= '0;
              bus.cout   <= 1'b0;
              bus.err    <= 1'b1;
              state      <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_en <= 1'b1;
          cnt    <= LAT_M1;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            bus.result <= alu_y;
            bus.cout   <= mask_cout(alu_op, alu_co);
            bus.err    <= 1'b0;
            state      <= RESP;
          end
        end
        RESP: begin
          // First RESP cycle raises rvalid, the second returns to IDLE
          if (bus.rvalid0 || bus.rvalid1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            bus.rvalid0 <= ~owner;
            bus.rvalid1 <= owner;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter with a behavioural 4-bit ALU slice.
module tb_alu_op_arbiter;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       alu_en;
  logic [3:0] alu_y;
  logic       alu_co;
  logic [4:0] alu_s;

  int checks = 0;
  int errors = 0;

  alu_op_arbiter_if bus ();

  alu_op_arbiter #(.ALU_LAT(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy   (busy),
    .alu_op (alu_op),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_en (alu_en),
    .alu_y  (alu_y),
    .alu_co (alu_co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU slice model; carry deliberately high for logic ops so masking is visible
  always_comb begin
    alu_s  = '0;
    alu_y  = '0;
    alu_co = 1'b1;
    case (alu_op)
      3'd0: alu_y = ~(alu_a | alu_b);
      3'd1: alu_y = alu_a & alu_b;
      3'd2: alu_y = alu_a | alu_b;
      3'd3: alu_y = alu_a ^ alu_b;
      3'd4: begin
        alu_s  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y  = alu_s[3:0];
        alu_co = alu_s[4];
      end
      3'd5: begin
        alu_s  = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
        alu_y  = alu_s[3:0];
        alu_co = alu_s[4];
      end
      default: alu_co = 1'b0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    int   gcnt;
    int   gcyc [4];
    int   gwho [4];

    rst_n = 1'b0;
    bus.req0 = 0; bus.req1 = 0;
    bus.op0 = 0; bus.op1 = 0;
    bus.a0_in = 0; bus.a1_in = 0; bus.b0_in = 0; bus.b1_in = 0;
    step(); step();

    check("rst_busy",   32'(busy), 0);
    check("rst_gnt0",   32'(bus.gnt0), 0);
    check("rst_rvalid", 32'({bus.rvalid0, bus.rvalid1}), 0);
    check("rst_alu_en", 32'(alu_en), 0);
    check("rst_result", 32'(bus.result), 0);
    check("rst_err",    32'(bus.err), 0);
    rst_n = 1'b1;

    // NOR on r0: 0101 NOR 0011 = 1000
    bus.req0 = 1; bus.op0 = 3'd0; bus.a0_in = 4'b0101; bus.b0_in = 4'b0011;
    step();
    check("nor_gnt0", 32'(bus.gnt0), 1);
    check("nor_gnt1", 32'(bus.gnt1), 0);
    check("nor_busy", 32'(busy), 1);
    check("nor_en_e0", 32'(alu_en), 0);
    bus.req0 = 0;
    step();
    check("nor_en_e1", 32'(alu_en), 1);
    check("nor_alu_a", 32'(alu_a), 5);
    check("nor_gnt0_off", 32'(bus.gnt0), 0);
    step();
    check("nor_en_e2", 32'(alu_en), 0);
    step();
    check("nor_rv_e3", 32'(bus.rvalid0), 0);
    step();
    check("nor_rv_e4", 32'(bus.rvalid0), 1);
    check("nor_result", 32'(bus.result), 8);
    check("nor_cout", 32'(bus.cout), 0);
    check("nor_err", 32'(bus.err), 0);
    step();
    check("nor_rv_off", 32'(bus.rvalid0), 0);
    check("nor_idle", 32'(busy), 0);

    // ADD overflow on r1: 1011 + 0110 = 1_0001
    bus.req1 = 1; bus.op1 = 3'd4; bus.a1_in = 4'b1011; bus.b1_in = 4'b0110;
    step();
    check("add_gnt1", 32'(bus.gnt1), 1);
    flag = bus.gnt0 | bus.rvalid0;
    bus.req1 = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      flag = flag | bus.gnt0 | bus.rvalid0;
    end
    check("add_rv1", 32'(bus.rvalid1), 1);
    check("add_result", 32'(bus.result), 1);
    check("add_cout", 32'(bus.cout), 1);
    check("add_r0_quiet", 32'(flag), 0);
    step();

    // SUB with borrow on r0: 0011 - 0101 = 1110, borrow-not 0
    bus.req0 = 1; bus.op0 = 3'd5; bus.a0_in = 4'b0011; bus.b0_in = 4'b0101;
    step();
    bus.req0 = 0;
    for (int i = 0; i < 4; i++) step();
    check("sub_rv0", 32'(bus.rvalid0), 1);
    check("sub_result", 32'(bus.result), 14);
    check("sub_cout", 32'(bus.cout), 0);
    step();

    // Reserved opcode on r0
    bus.req0 = 1; bus.op0 = 3'd7;
    step();
    check("rsv_gnt0", 32'(bus.gnt0), 1);
    flag = alu_en;
    bus.req0 = 0;
    step();
    flag = flag | alu_en;
    check("rsv_rv0", 32'(bus.rvalid0), 1);
    check("rsv_err", 32'(bus.err), 1);
    check("rsv_result", 32'(bus.result), 0);
    check("rsv_cout", 32'(bus.cout), 0);
    step();
    flag = flag | alu_en;
    check("rsv_no_en", 32'(flag), 0);
    check("rsv_idle", 32'(busy), 0);

    // Contention after reset: r0 AND, r1 OR, both held high
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.req0 = 1; bus.op0 = 3'd1; bus.a0_in = 4'b1100; bus.b0_in = 4'b1010;
    bus.req1 = 1; bus.op1 = 3'd2; bus.a1_in = 4'b1010; bus.b1_in = 4'b0101;
    gcnt = 0;
    flag = 1'b0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      step();
      flag = flag | (bus.gnt0 & bus.gnt1) | (bus.rvalid0 & bus.rvalid1);
      if (bus.gnt0 || bus.gnt1) begin
        gwho[gcnt] = bus.gnt1 ? 1 : 0;
        gcyc[gcnt] = c;
        gcnt++;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    check("rr_count", gcnt, 4);
    if (gcnt == 4) begin
      check("rr_who0", gwho[0], 0);
      check("rr_who1", gwho[1], 1);
      check("rr_who2", gwho[2], 0);
      check("rr_who3", gwho[3], 1);
      check("rr_gap1", gcyc[1] - gcyc[0], 6);
      check("rr_gap2", gcyc[2] - gcyc[1], 6);
      check("rr_gap3", gcyc[3] - gcyc[2], 6);
    end
    for (int i = 0; i < 4; i++) step();
    check("rr_or_rv1", 32'(bus.rvalid1), 1);
    check("rr_or_result", 32'(bus.result), 15);
    check("rr_exclusive", 32'(flag), 0);
    step();

    // Reset during WAIT drops the ADD in flight
    bus.req0 = 1; bus.op0 = 3'd4; bus.a0_in = 4'b0001; bus.b0_in = 4'b0001;
    step();
    bus.req0 = 0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_alu", 32'({alu_en, alu_op, alu_a, alu_b}), 0);
    check("mrst_outs", 32'({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.cout, bus.err}), 0);
    check("mrst_result", 32'(bus.result), 0);
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      flag = flag | bus.rvalid0 | bus.rvalid1;
    end
    check("mrst_no_rv", 32'(flag), 0);
    bus.req0 = 1; bus.req1 = 1; bus.op0 = 3'd1; bus.op1 = 3'd1;
    step();
    check("mrst_tie_r0", 32'({bus.gnt1, bus.gnt0}), 1);
    bus.req0 = 0; bus.req1 = 0;
    for (int i = 0; i < 6; i++) step();

    // Request while busy is ignored; operand change after grant has no effect
    bus.req0 = 1; bus.op0 = 3'd3; bus.a0_in = 4'b1100; bus.b0_in = 4'b1010;
    step();
    bus.req0 = 0;
    step();
    bus.req1 = 1; bus.op1 = 3'd1; bus.a0_in = 4'b1111;
    step();
    flag = bus.gnt1;
    bus.req1 = 0;
    step();
    flag = flag | bus.gnt1;
    step();
    check("busy_rv0", 32'(bus.rvalid0), 1);
    check("busy_result", 32'(bus.result), 6);
    for (int i = 0; i < 4; i++) begin
      step();
      flag = flag | bus.gnt1;
    end
    check("busy_no_gnt1", 32'(flag), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
